// File: rtl/avalon_reg_master_pkg.sv
// avalon_reg_master_pkg
// Shared types and constants for the register-driven Avalon-MM master.
//   state_e     : master FSM state (idle, write in flight, read in flight)
//   ST_*        : bit positions inside the 4-bit status word
package avalon_reg_master_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_RD_VALID = 1;
  localparam int unsigned ST_OVERRUN  = 2;
  localparam int unsigned ST_TIMEOUT  = 3;

endpackage

// File: rtl/av_timeout_counter.sv
// av_timeout_counter
// Counts consecutive stalled cycles and flags the cycle in which the LIMIT-th
// consecutive stall is seen, so the owner can abort on the following edge.
// Ports:
//   clk      : clock
//   reset    : asynchronous active-high reset
//   clear    : restart the count (no stall this cycle / new transaction)
//   count_en : a stalled cycle is in progress
//   expired  : combinational; high during the LIMIT-th consecutive stall cycle
module av_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CntW-1:0] count_q, count_d;

  // count_q holds the number of stall cycles already completed
  assign expired = count_en && (count_q == CntW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/avalon_reg_master.sv
// avalon_reg_master
// Register-driven Avalon-MM master: the MCU loads address/control/write data
// and starts single reads or writes; busy stalls the MCU while the slave holds
// waitrequest. Optional waitrequest timeout when AV_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   addr_load/addr_in          : load the address register
//   ctrl_load/ctrl_in          : load control (bit0 = auto-increment enable)
//   wdata_load/wdata_in        : load write data and start a write
//   rd_start                   : start a read at the current address
//   status_clear               : clear sticky timeout/overrun/rd_valid
//   rdata                      : last captured read data
//   status                     : {timeout, overrun, rd_valid, busy}
//   busy                       : MCU stall (strobe high and waitrequest high)
//   av_*                       : Avalon-MM master port
module avalon_reg_master
  import avalon_reg_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_STRIDE    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  ctrl_load,
  input  logic                  ctrl_in,
  input  logic                  wdata_load,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  rd_start,
  input  logic                  status_clear,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            status,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic [DATA_WIDTH-1:0] av_writedata,
  output logic                  av_write,
  output logic                  av_read,
  input  logic [DATA_WIDTH-1:0] av_readdata,
  input  logic                  av_waitrequest
);

  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(ADDR_STRIDE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ctrl_q, ctrl_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic strobe, complete, accept, cmd_any, start_wr, start_rd, abort;
  logic rd_set, overrun_set;

  assign av_write     = (state_q == StWrite);
  assign av_read      = (state_q == StRead);
  assign av_address   = addr_q;
  assign av_writedata = wdata_q;
  assign rdata        = rdata_q;

  assign strobe   = av_write | av_read;
  assign busy     = strobe & av_waitrequest;
  assign complete = strobe & ~av_waitrequest;
  // A completion cycle is not busy, so a new command chains with no idle cycle
  assign accept   = ~busy;
  assign cmd_any  = addr_load | ctrl_load | wdata_load | rd_start;
  assign start_wr = accept & wdata_load;
  assign start_rd = accept & rd_start & ~wdata_load;

`ifdef AV_MASTER_TIMEOUT_EN
  av_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy),
    .count_en(busy),
    .expired (abort)
  );
`else
  assign abort = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_RD_VALID] = rd_valid_q;
    status[ST_OVERRUN]  = overrun_q;
    status[ST_TIMEOUT]  = timeout_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ctrl_d      = ctrl_q;
    rd_valid_d  = rd_valid_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    rd_set      = complete && (state_q == StRead);
    overrun_set = (busy && cmd_any) || (accept && wdata_load && rd_start);

    if (complete || abort) begin
      state_d = StIdle;
    end
    if (start_wr) begin
      state_d = StWrite;
      wdata_d = wdata_in;
    end else if (start_rd) begin
      state_d = StRead;
    end

    // Increment uses the control value in force before this edge
    if (complete && ctrl_q) begin
      addr_d = addr_q + AddrStep;
    end
    if (accept && addr_load) begin
      addr_d = addr_in;
    end
    if (accept && ctrl_load) begin
      ctrl_d = ctrl_in;
    end

    if (rd_set) begin
      rdata_d = av_readdata;
    end else if (abort && (state_q == StRead)) begin
      rdata_d = '1;
    end

    if (rd_set) begin
      rd_valid_d = 1'b1;
    end else if (start_rd || status_clear) begin
      rd_valid_d = 1'b0;
    end

    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (status_clear) begin
      overrun_d = 1'b0;
    end

    if (abort) begin
      timeout_d = 1'b1;
    end else if (status_clear) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ctrl_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_avalon_reg_master.sv
// tb_avalon_reg_master
// Self-checking bench for avalon_reg_master: directed scenarios plus a random
// command stream. Expected bus transactions are queued when commands are
// issued and checked by a monitor as the slave completes them.
module tb_avalon_reg_master;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned STRIDE = 1;
  localparam int unsigned TO     = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          addr_load, ctrl_load, ctrl_in, wdata_load, rd_start, status_clear;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata_in;
  logic [DW-1:0] rdata;
  logic [3:0]    status;
  logic          busy;
  logic [AW-1:0] av_address;
  logic [DW-1:0] av_writedata, av_readdata;
  logic          av_write, av_read, av_waitrequest;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  int            wait_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] addr_m = '0;
  bit            inc_m = 1'b0;
  bit            chk_rd = 1'b0;
  logic [DW-1:0] exp_rd;
  txn_t          mon_t;

  avalon_reg_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ADDR_STRIDE   (STRIDE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .addr_load     (addr_load),
    .addr_in       (addr_in),
    .ctrl_load     (ctrl_load),
    .ctrl_in       (ctrl_in),
    .wdata_load    (wdata_load),
    .wdata_in      (wdata_in),
    .rd_start      (rd_start),
    .status_clear  (status_clear),
    .rdata         (rdata),
    .status        (status),
    .busy          (busy),
    .av_address    (av_address),
    .av_writedata  (av_writedata),
    .av_write      (av_write),
    .av_read       (av_read),
    .av_readdata   (av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  always #5 clk = ~clk;

  // Slave memory contents: a fixed function of the address (0 -> 0x1234)
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = a * 16'h9E37;
    return v ^ 16'h1234;
  endfunction

  assign av_readdata = mem_fn(av_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: picks a waitrequest count per transaction, drives just after posedge
  initial begin
    int left;
    bit in_txn;
    av_waitrequest = 1'b0;
    left = 0;
    in_txn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (av_write || av_read) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          left = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, 3));
        end
        if (left > 0) begin
          av_waitrequest = 1'b1;
          left--;
        end else begin
          av_waitrequest = 1'b0;
          in_txn = 1'b0;
        end
      end else begin
        av_waitrequest = 1'b0;
        in_txn = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed bus transaction
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_rule", busy, (av_write | av_read) & av_waitrequest);
      if (chk_rd) begin
        check("rdata", rdata, exp_rd);
        chk_rd = 1'b0;
      end
      if ((av_write || av_read) && !av_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: wr=%0b addr=%0h with no transaction expected",
                   av_write, av_address);
        end else begin
          mon_t = exp_q.pop_front();
          check("txn_kind", av_write, mon_t.is_wr);
          check("txn_addr", av_address, mon_t.addr);
          if (mon_t.is_wr) begin
            check("txn_wdata", av_writedata, mon_t.data);
          end else begin
            chk_rd = 1'b1;
            exp_rd = mon_t.data;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Issue one command cycle (called at a negedge) and update the model
  task automatic issue(input bit al, input logic [AW-1:0] a, input bit cl, input bit c,
                       input bit wr, input logic [DW-1:0] d, input bit rd);
    txn_t t;
    wait_idle();
    addr_load  = al;
    addr_in    = a;
    ctrl_load  = cl;
    ctrl_in    = c;
    wdata_load = wr;
    wdata_in   = d;
    rd_start   = rd;
    if (cl) inc_m = c;
    if (al) addr_m = a;
    if (wr || rd) begin
      t.is_wr = wr;
      t.addr  = addr_m;
      t.data  = wr ? d : mem_fn(addr_m);
      exp_q.push_back(t);
      if (inc_m) addr_m = AW'(addr_m + STRIDE);
    end
    @(negedge clk);
    addr_load  = 1'b0;
    ctrl_load  = 1'b0;
    wdata_load = 1'b0;
    rd_start   = 1'b0;
  endtask

  task automatic measure(input int cycles, output int s, output int b);
    s = 0;
    b = 0;
    for (int i = 0; i < cycles; i++) begin
      if (av_write || av_read) s++;
      if (busy) b++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    status_clear = 1'b1;
    @(negedge clk);
    status_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, b, n;
    bit al, cl, c;
    int op;
    reset = 1'b1;
    addr_load = 0; ctrl_load = 0; ctrl_in = 0; wdata_load = 0; rd_start = 0;
    status_clear = 0; addr_in = '0; wdata_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_status", status, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", av_address, 0);
    check("rst_wdata", av_writedata, 0);
    check("rst_write", av_write, 0);
    check("rst_read", av_read, 0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait write
    issue(1, 16'h0010, 0, 0, 0, '0, 0);
    wait_q.push_back(0);
    issue(0, '0, 0, 0, 1, 16'hBEEF, 0);
    measure(6, s, b);
    check("zw_strobe_cycles", s, 1);
    check("zw_busy_cycles", b, 0);

    // Read with 3 waitrequest cycles at address 0 (data 0x1234)
    issue(1, 16'h0000, 1, 0, 0, '0, 0);
    wait_q.push_back(3);
    issue(0, '0, 0, 0, 0, '0, 1);
    measure(8, s, b);
    check("rd3_strobe_cycles", s, 4);
    check("rd3_busy_cycles", b, 3);
    check("rd3_rdata", rdata, 16'h1234);
    check("rd3_rd_valid", status[1], 1);

    // Auto-increment wrap, back-to-back zero-wait writes
    issue(1, 16'hFFFF, 1, 1, 0, '0, 0);
    wait_q.push_back(0);
    wait_q.push_back(0);
    issue(0, '0, 0, 0, 1, 16'h00A1, 0);
    issue(0, '0, 0, 0, 1, 16'h00A2, 0);
    measure(3, s, b);
    check("wrap_final_addr", av_address, 16'h0001);
    check("wrap_model_addr", av_address, addr_m);

    // Overrun: write pulse while busy is ignored
    issue(1, 16'h0100, 1, 0, 0, '0, 0);
    wait_q.push_back(4);
    issue(0, '0, 0, 0, 1, 16'h1111, 0);
    check("ovr_busy_seen", busy, 1);
    wdata_load = 1'b1;
    wdata_in   = 16'h2222;
    @(negedge clk);
    wdata_load = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ovr_set", status[2], 1);
    check("ovr_wdata_kept", av_writedata, 16'h1111);
    pulse_clear();
    check("ovr_cleared", status[2], 0);

    // Write and read together: write wins, overrun set
    wait_q.push_back(0);
    issue(0, '0, 0, 0, 1, 16'h3333, 1);
    measure(4, s, b);
    check("dual_strobe_cycles", s, 1);
    check("dual_overrun", status[2], 1);
    pulse_clear();

`ifdef AV_MASTER_TIMEOUT_EN
    issue(1, 16'h0200, 0, 0, 0, '0, 0);
    wait_q.push_back(1000);
    issue(0, '0, 0, 0, 0, '0, 1);
    void'(exp_q.pop_back());
    measure(14, s, b);
    check("to_strobe_cycles", s, TO);
    check("to_flag", status[3], 1);
    check("to_rdata", rdata, 16'hFFFF);
    check("to_rd_valid", status[1], 0);
    pulse_clear();
    check("to_cleared", status[3], 0);
`endif

    // Random command stream
    for (int i = 0; i < 300; i++) begin
      al = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 5) == 0);
      c  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 2);
      issue(al, AW'($urandom), cl, c, op == 1, DW'($urandom), op == 2);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
    check("rand_final_addr", av_address, addr_m);
    check("rand_no_overrun", status[2], 0);

    // Reset during a stalled write
    wait_q.push_back(10);
    issue(0, '0, 0, 0, 1, 16'h5555, 0);
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_write", av_write, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_status", status, 0);
    check("mid_rst_addr", av_address, 0);
    check("mid_rst_wdata", av_writedata, 0);
    check("mid_rst_rdata", rdata, 0);
    exp_q.delete();
    chk_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
